ram4_hs: RTL

RAM4_HS -- requirements
Module: ram4_hs

---
 rtl/hack_pkg.sv | 13 +
 rtl/dmux4way.sv | 16 +
 rtl/ram4_hs.sv | 91 +++++++++
 3 files changed

// File: rtl/hack_pkg.sv
// Shared widths and the handshake FSM state type for the Hack 4-word RAM.
package hack_pkg;

   localparam int unsigned WORD_W = 16;
   localparam int unsigned ADDR_W = 2;
   localparam int unsigned NWORDS = 4;

   typedef enum logic {
      IDLE = 1'b0,
      RESP = 1'b1
   } state_t;

endpackage

// File: rtl/dmux4way.sv
// Hack 1-to-4 demultiplexer: routes in to the output picked by sel, others 0.
module dmux4way (
   input  logic       in,
   input  logic [1:0] sel,
   output logic       a,
   output logic       b,
   output logic       c,
   output logic       d
);

   assign a = in & (sel == 2'd0);
   assign b = in & (sel == 2'd1);
   assign c = in & (sel == 2'd2);
   assign d = in & (sel == 2'd3);

endmodule

// File: rtl/ram4_hs.sv
// Four-word RAM behind a valid/ready request/response handshake, one txn/cycle.
// Define RAM4_RESET_CLEAR_EN to make rst clear the stored words as well.
module ram4_hs
   import hack_pkg::*;
#(
   parameter int unsigned WIDTH = WORD_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [WIDTH-1:0]  req_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [WIDTH-1:0]  rsp_data
);

   state_t              state;
   logic [WIDTH-1:0]    mem [NWORDS];
   logic [NWORDS-1:0]   word_we;
   logic                accept;
   logic                wr_accept;
   logic [WIDTH-1:0]    rsp_next;

   // A pending response frees the request side only when it is being taken.
   assign req_ready = (state == IDLE) | rsp_ready;
   assign accept    = req_valid & req_ready;
   assign wr_accept = accept & req_we;
   assign rsp_next  = req_we ? req_wdata : mem[req_addr];

   dmux4way u_we_dmux (
      .in  (wr_accept),
      .sel (req_addr),
      .a   (word_we[0]),
      .b   (word_we[1]),
      .c   (word_we[2]),
      .d   (word_we[3])
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         rsp_valid <= 1'b0;
         rsp_data  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  state     <= RESP;
                  rsp_valid <= 1'b1;
                  rsp_data  <= rsp_next;
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  if (accept) begin
                     rsp_data <= rsp_next;
                  end else begin
                     state     <= IDLE;
                     rsp_valid <= 1'b0;
                  end
               end
            end
            default: begin
               state     <= IDLE;
               rsp_valid <= 1'b0;
            end
         endcase
      end
   end

`ifdef RAM4_RESET_CLEAR_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < int'(NWORDS); i++) mem[i] <= '0;
      end else begin
         for (int i = 0; i < int'(NWORDS); i++)
            if (word_we[i]) mem[i] <= req_wdata;
      end
   end
`else
   // Storage has no reset so contents survive rst.
   always_ff @(posedge clk) begin
      for (int i = 0; i < int'(NWORDS); i++)
         if (word_we[i]) mem[i] <= req_wdata;
   end
`endif

endmodule
